alu_cmd_sequencer: RTL and testbench

//  Upstream issue stage for the registered 8-bit ALU. Buffers {opcode,A,B} commands in a

---
 rtl/alu_cmd_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command issue to a registered ALU with valid/ready response capture
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int OPW   = 5,
   parameter int DW    = 8,
   parameter int RW    = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [OPW-1:0] cmd_opcode,
   input  logic [DW-1:0]  cmd_a,
   input  logic [DW-1:0]  cmd_b,
   output logic [OPW-1:0] alu_opcode,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   input  logic [RW-1:0]  alu_result,
   input  logic           alu_carry,
   input  logic           alu_overflow,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [OPW-1:0] rsp_opcode,
   output logic [RW-1:0]  rsp_result,
   output logic           rsp_carry,
   output logic           rsp_overflow,
   output logic           rsp_zero,
   output logic           busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
   typedef struct packed {
      logic [OPW-1:0] op;
      logic [DW-1:0]  a;
      logic [DW-1:0]  b;
   } cmd_t;
   state_t         state_q, state_d;
   cmd_t           mem_q [DEPTH];
   cmd_t           mem_d [DEPTH];
   logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]    cnt_q, cnt_d;
   logic [OPW-1:0] alu_opcode_q, alu_opcode_d, rsp_opcode_q, rsp_opcode_d;
   logic [DW-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [RW-1:0]  rsp_result_q, rsp_result_d;
   logic           rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d;
   logic           rsp_overflow_q, rsp_overflow_d, rsp_zero_q, rsp_zero_d;
   logic           full, empty, push, pop, arith;
   // Next-state: FIFO bookkeeping, issue pop, result capture and the response handshake
   always_comb begin
      full           = cnt_q == FULL_CNT;
      empty          = cnt_q == '0;
      push           = cmd_valid && !full;
      pop            = !empty && (state_q == IDLE || (state_q == RESP && rsp_ready));
      arith          = alu_opcode_q[OPW-1:1] == '0;
      mem_d          = mem_q;
      wp_d           = push ? wp_q + 1'b1 : wp_q;
      rp_d           = pop ? rp_q + 1'b1 : rp_q;
      cnt_d          = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      alu_opcode_d   = pop ? mem_q[rp_q].op : alu_opcode_q;
      alu_a_d        = pop ? mem_q[rp_q].a : alu_a_q;
      alu_b_d        = pop ? mem_q[rp_q].b : alu_b_q;
      state_d        = state_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_opcode_d   = rsp_opcode_q;
      rsp_result_d   = rsp_result_q;
      rsp_carry_d    = rsp_carry_q;
      rsp_overflow_d = rsp_overflow_q;
      rsp_zero_d     = rsp_zero_q;
      if (push) mem_d[wp_q] = '{op: cmd_opcode, a: cmd_a, b: cmd_b};
      case (state_q)
         IDLE:  state_d = pop ? ISSUE : IDLE;
         ISSUE: state_d = CAPT;
         CAPT: begin
            rsp_valid_d    = 1'b1;
            rsp_opcode_d   = alu_opcode_q;
            rsp_result_d   = alu_result;
            rsp_carry_d    = arith && alu_carry;
            rsp_overflow_d = arith && alu_overflow;
            rsp_zero_d     = alu_result == '0;
            state_d        = RESP;
         end
         RESP: begin
            rsp_valid_d = !rsp_ready;
            state_d     = !rsp_ready ? RESP : pop ? ISSUE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // State registers; reset discards queued and in-flight commands
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         mem_q          <= '{default: '0};
         wp_q           <= '0;
         rp_q           <= '0;
         cnt_q          <= '0;
         alu_opcode_q   <= '0;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_opcode_q   <= '0;
         rsp_result_q   <= '0;
         rsp_carry_q    <= 1'b0;
         rsp_overflow_q <= 1'b0;
         rsp_zero_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_q          <= mem_d;
         wp_q           <= wp_d;
         rp_q           <= rp_d;
         cnt_q          <= cnt_d;
         alu_opcode_q   <= alu_opcode_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_opcode_q   <= rsp_opcode_d;
         rsp_result_q   <= rsp_result_d;
         rsp_carry_q    <= rsp_carry_d;
         rsp_overflow_q <= rsp_overflow_d;
         rsp_zero_q     <= rsp_zero_d;
      end
   end
   assign cmd_ready    = !full;
   assign busy         = state_q != IDLE || !empty;
   assign alu_opcode   = alu_opcode_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_opcode   = rsp_opcode_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_carry    = rsp_carry_q;
   assign rsp_overflow = rsp_overflow_q;
   assign rsp_zero     = rsp_zero_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed vectors and multi-cycle corner sequences for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
   logic        clk = 1'b0, reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, rsp_ready = 1'b0;
   logic [4:0]  cmd_opcode = '0, alu_opcode, rsp_opcode;
   logic [7:0]  cmd_a = '0, cmd_b = '0, alu_a, alu_b;
   logic [15:0] alu_result = '0, rsp_result;
   logic        alu_carry = 1'b0, alu_overflow = 1'b0;
   logic        rsp_valid, rsp_carry, rsp_overflow, rsp_zero, busy;
   int          n_cmp = 0, n_err = 0;
   typedef struct {
      logic [4:0]  op;
      logic [7:0]  a, b;
      logic [15:0] res;
      logic        c, v, z;
   } vec_t;
   vec_t vecs [8];

   alu_cmd_sequencer dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_opcode(rsp_opcode),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
      .rsp_zero(rsp_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   // Registered ALU stand-in; non-add/sub ops drive junk flags high so masking is exercised
   logic [8:0] add9, sub9;
   assign add9 = {1'b0, alu_a} + {1'b0, alu_b};
   assign sub9 = {1'b0, alu_a} - {1'b0, alu_b};
   always @(posedge clk) begin
      alu_carry    <= 1'b1;
      alu_overflow <= 1'b1;
      alu_result   <= '0;
      if (alu_opcode == 5'd0) begin
         alu_result   <= {8'h00, add9[7:0]};
         alu_carry    <= add9[8];
         alu_overflow <= (alu_a[7] == alu_b[7]) && (add9[7] != alu_a[7]);
      end else if (alu_opcode == 5'd1) begin
         alu_result   <= {8'h00, sub9[7:0]};
         alu_carry    <= sub9[8];
         alu_overflow <= (alu_a[7] != alu_b[7]) && (sub9[7] != alu_a[7]);
      end else if (alu_opcode == 5'd3) begin
         alu_result <= (alu_b == 0) ? 16'h0000 : {alu_a % alu_b, alu_a / alu_b};
      end else if (alu_opcode == 5'd8) begin
         alu_result <= {8'h00, alu_a & alu_b};
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (rsp_valid) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_rsp(input string nm, input vec_t v);
      chk({nm, "_op"}, {27'd0, rsp_opcode}, {27'd0, v.op});
      chk({nm, "_res"}, {16'd0, rsp_result}, {16'd0, v.res});
      chk({nm, "_flags"}, {29'd0, rsp_carry, rsp_overflow, rsp_zero}, {29'd0, v.c, v.v, v.z});
   endtask

   initial begin
      bit ok;
      int got, last, highs;
      vecs[0] = '{5'd0, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{5'd1, 8'h05, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{5'd8, 8'hF0, 8'h0F, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{5'd3, 8'd17, 8'd5,  16'h0203, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{5'd3, 8'd17, 8'd0,  16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{5'd0, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{5'd1, 8'h80, 8'h01, 16'h007F, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{5'd1, 8'h00, 8'h01, 16'h00FF, 1'b1, 1'b0, 1'b0};
      repeat (2) @(negedge clk);
      chk("reset_state", {cmd_ready, rsp_valid, busy, alu_opcode, alu_a, alu_b, rsp_zero},
          {1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 8'd0, 1'b0});
      reset = 1'b0;
      // Latency: push at t0 -> rsp_valid only after t3
      @(negedge clk);
      rsp_ready = 1'b1;
      {cmd_opcode, cmd_a, cmd_b} = {5'd0, 8'h7F, 8'h01};
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("lat_t0", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("lat_t1", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("lat_t2", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("lat_t3", {31'd0, rsp_valid}, 32'd1);
      check_rsp("lat", vecs[0]);
      @(negedge clk);
      // Table-driven single commands
      for (int i = 0; i < 8; i++) begin
         {cmd_opcode, cmd_a, cmd_b} = {vecs[i].op, vecs[i].a, vecs[i].b};
         cmd_valid = 1'b1;
         @(negedge clk);
         cmd_valid = 1'b0;
         wait_rsp(ok);
         if (ok) check_rsp($sformatf("vec%0d", i), vecs[i]);
         @(negedge clk);
      end
      // Backpressure: five pushes fill the FIFO, then drain in order at 3-clk spacing
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("fill_ready%0d", i), {31'd0, cmd_ready}, 32'd1);
         {cmd_opcode, cmd_a, cmd_b} = {5'd0, 8'(i), 8'h10};
         cmd_valid = 1'b1;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("full_ready", {31'd0, cmd_ready}, 32'd0);
      rsp_ready = 1'b1;
      got = 0;
      last = 0;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         if (rsp_valid) begin
            chk($sformatf("order%0d", got), {16'd0, rsp_result}, 32'h10 + got);
            if (got > 0) chk($sformatf("gap%0d", got), cyc - last, 32'd3);
            last = cyc;
            got++;
         end
         @(negedge clk);
      end
      chk("drain_count", got, 32'd5);
      // Hold in RESP for 10 clk with a second command queued behind
      rsp_ready = 1'b0;
      {cmd_opcode, cmd_a, cmd_b} = {5'd0, 8'h20, 8'h03};
      cmd_valid = 1'b1;
      @(negedge clk);
      {cmd_opcode, cmd_a, cmd_b} = {5'd0, 8'h40, 8'h01};
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_rsp(ok);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("hold%0d", i), {7'd0, rsp_valid, rsp_result, alu_a}, {7'd0, 1'b1, 16'h0023, 8'h20});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      wait_rsp(ok);
      if (ok) chk("hold_next", {16'd0, rsp_result}, 32'h0041);
      @(negedge clk);
      // Reset during ISSUE with three commands still queued
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         {cmd_opcode, cmd_a, cmd_b} = {5'd0, 8'(i + 1), 8'h00};
         cmd_valid = 1'b1;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("pre_reset", {23'd0, busy, alu_a}, {23'd0, 1'b1, 8'd2});
      #2 reset = 1'b1;
      #1;
      chk("async_reset", {cmd_ready, rsp_valid, busy, alu_opcode, alu_a, alu_b, rsp_zero},
          {1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 8'd0, 1'b0});
      chk("async_reset_rsp", {rsp_result, rsp_opcode, rsp_carry, rsp_overflow}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) highs++;
      end
      chk("post_reset_quiet", highs, 32'd0);
      chk("post_reset_idle", {31'd0, busy}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
